// File: rtl/wb_spiflash_reader.sv
// wb_spiflash_reader: read-only Wishbone classic slave serving 32-bit words from SPI NOR flash via the READ command
module wb_spiflash_reader #(
  parameter int          CLK_DIV   = 2,
  parameter int          ADDR_BITS = 24,
  parameter logic [7:0]  READ_CMD  = 8'h03
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int W = 8 + ADDR_BITS;
  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  state_t state, state_n;
  logic [31:0] tx, tx_n, rx, rx_n, dat_n;
  logic [5:0] bit_cnt, bit_n;
  logic [7:0] div_cnt, div_n;
  logic cs_n_n, sclk_n, mosi_n, ack_n, busy_n;
  logic [W-1:0] cmd_full;
  logic [63:0] cmd_ext;
  logic req, div_end, unused;
  assign cmd_full = {READ_CMD, wb_adr_i[ADDR_BITS-1:2], 2'b00};
  assign cmd_ext = {cmd_full, {(64-W){1'b0}}};
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign div_end = div_cnt == DIV_MAX;
  assign unused = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_BITS], wb_adr_i[1:0], cmd_ext[31:0]};
  always_comb begin
    state_n = state;
    tx_n = tx;
    rx_n = rx;
    dat_n = wb_dat_o;
    bit_n = bit_cnt;
    div_n = div_cnt;
    cs_n_n = spi_cs_n;
    sclk_n = spi_sclk;
    mosi_n = spi_mosi;
    busy_n = busy;
    ack_n = 1'b0;
    case (state)
      IDLE: begin
        if (req && !wb_we_i) begin
          tx_n = cmd_ext[63:32];
          mosi_n = cmd_ext[63];
          cs_n_n = 1'b0;
          busy_n = 1'b1;
          bit_n = '0;
          div_n = '0;
          state_n = SHIFT;
        end else if (req) ack_n = 1'b1;
      end
      SHIFT: begin
        div_n = div_end ? 8'd0 : div_cnt + 8'd1;
        if (div_end && !spi_sclk) begin
          sclk_n = 1'b1;
          rx_n = {rx[30:0], spi_miso};
        end else if (div_end) begin
          // falling edge: present the next tx bit; zeros flow in once the command word is exhausted
          sclk_n = 1'b0;
          tx_n = {tx[30:0], 1'b0};
          mosi_n = bit_cnt == 6'd63 ? 1'b0 : tx[30];
          bit_n = bit_cnt + 6'd1;
          cs_n_n = bit_cnt == 6'd63;
          state_n = bit_cnt == 6'd63 ? DONE : SHIFT;
        end
      end
      default: begin
        ack_n = wb_cyc_i;
        dat_n = wb_cyc_i ? {rx[7:0], rx[15:8], rx[23:16], rx[31:24]} : wb_dat_o;
        busy_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      tx <= tx_n;
      rx <= rx_n;
      bit_cnt <= bit_n;
      div_cnt <= div_n;
      wb_dat_o <= dat_n;
      wb_ack_o <= ack_n;
      spi_cs_n <= cs_n_n;
      spi_sclk <= sclk_n;
      spi_mosi <= mosi_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_wb_spiflash_reader.sv
// tb_wb_spiflash_reader: directed vectors against a behavioural SPI NOR flash model
module tb_wb_spiflash_reader;
  localparam int CLK_DIV = 2;
  logic clock = 0, resetn = 0;
  logic [31:0] wb_adr_i = 0, wb_dat_i = 0, wb_dat_o;
  logic [3:0] wb_sel_i = 4'hf;
  logic wb_we_i = 0, wb_cyc_i = 0, wb_stb_i = 0, wb_ack_o;
  logic spi_cs_n, spi_sclk, spi_mosi, spi_miso, busy;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem [0:255];
  logic [31:0] cmd_sr = 0;
  int nrise = 0, last_n = 0, total_rises = 0;
  int lowrun = 0, highrun = 0, last_low = 0, windows = 0, min_gap = 1000000;

  wb_spiflash_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .resetn(resetn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy));

  always #5 clock = ~clock;

  function automatic logic flash_bit(int n, logic [31:0] c);
    logic [7:0] b;
    if (n < 32 || n >= 64) return 1'b0;
    b = mem[8'(c[7:0] + 8'((n - 32) / 8))];
    return b[3'(7 - (n - 32) % 8)];
  endfunction
  assign spi_miso = flash_bit(nrise, cmd_sr);

  // flash: command/address captured on rising sclk, data presented during the low phase
  always @(posedge spi_sclk or posedge spi_cs_n)
    if (spi_cs_n) begin
      if (nrise != 0) last_n <= nrise;
      nrise <= 0;
    end else begin
      if (nrise < 32) cmd_sr <= {cmd_sr[30:0], spi_mosi};
      nrise <= nrise + 1;
      total_rises <= total_rises + 1;
    end

  always @(posedge clock)
    if (spi_cs_n === 1'b0) begin
      if (lowrun == 0) begin
        windows <= windows + 1;
        if (windows > 0 && highrun < min_gap) min_gap <= highrun;
      end
      lowrun <= lowrun + 1;
      highrun <= 0;
    end else begin
      if (lowrun != 0) last_low <= lowrun;
      lowrun <= 0;
      highrun <= highrun + 1;
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic hold, output int lat);
    @(negedge clock);
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_cyc_i = 1; wb_stb_i = 1;
    lat = 0;
    forever begin
      @(posedge clock); #1;
      if (wb_ack_o || lat > 3000) break;
      lat++;
    end
    if (!hold) begin
      @(negedge clock);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    end
  endtask

  typedef struct {
    logic we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    logic [31:0] exp_cmd;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int lat, w0, r0;
    logic [31:0] d0;
    logic ack_seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'ha5;
    mem[16] = 8'h13; mem[17] = 8'h05; mem[18] = 8'h00; mem[19] = 8'h00;
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 32'h0000_0513, 32'h0300_0010};
    vecs[1] = '{1'b0, 32'hff00_0007, 32'h0, 32'ha2a3_a0a1, 32'h0300_0004};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'hdead_beef, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0, 32'ha6a7_a4a5, 32'h0300_0000};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0, 32'haeaf_acad, 32'h0300_0008};

    repeat (3) @(posedge clock);
    @(negedge clock) resetn = 1;
    chk("reset_state", {spi_cs_n, spi_sclk, spi_mosi, wb_ack_o, busy, wb_dat_o}, {5'b10000, 32'h0});

    for (int i = 0; i < 5; i++) begin
      w0 = windows; r0 = total_rises;
      do_req(vecs[i].we, vecs[i].adr, vecs[i].dat, 1'b0, lat);
      if (vecs[i].we) begin
        chk("wr_ack_latency", lat, 0);
        chk("wr_no_spi", {windows, total_rises}, {w0, r0});
      end else begin
        chk("rd_ack_latency", lat, 1 + 128 * CLK_DIV);
        chk("rd_data", wb_dat_o, vecs[i].exp_dat);
        chk("rd_mosi_stream", cmd_sr, vecs[i].exp_cmd);
        chk("rd_cs_low_cycles", last_low, 128 * CLK_DIV);
        chk("rd_sclk_bits", last_n, 64);
      end
      repeat (3) @(negedge clock);
    end

    w0 = windows;
    do_req(1'b0, 32'h0, 32'h0, 1'b1, lat);
    d0 = wb_dat_o;
    chk("b2b_first_data", d0, 32'ha6a7_a4a5);
    do_req(1'b0, 32'h4, 32'h0, 1'b0, lat);
    chk("b2b_second_latency", lat, 2 + 128 * CLK_DIV);
    chk("b2b_second_data", wb_dat_o, 32'ha2a3_a0a1);
    chk("b2b_two_windows", windows, w0 + 2);
    chk("b2b_gap_ok", min_gap >= 1, 1);
    repeat (3) @(negedge clock);

    wb_adr_i = 32'h10; wb_we_i = 0; wb_cyc_i = 1; wb_stb_i = 1;
    repeat (100) @(posedge clock);
    @(negedge clock) resetn = 0;
    @(posedge clock); #1;
    chk("reset_mid_outputs", {spi_cs_n, spi_sclk, busy, wb_ack_o, wb_dat_o}, {4'b1000, 32'h0});
    @(negedge clock);
    resetn = 1; wb_cyc_i = 0; wb_stb_i = 0;
    repeat (2) @(negedge clock);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, lat);
    chk("post_reset_latency", lat, 1 + 128 * CLK_DIV);
    chk("post_reset_data", wb_dat_o, 32'h0000_0513);
    repeat (3) @(negedge clock);

    wb_adr_i = 32'h4; wb_we_i = 0; wb_cyc_i = 1; wb_stb_i = 1;
    repeat (50) @(posedge clock);
    @(negedge clock);
    wb_cyc_i = 0; wb_stb_i = 0;
    ack_seen = 0;
    for (int k = 0; k < 600 && (busy || !spi_cs_n); k++) begin
      @(posedge clock); #1;
      if (wb_ack_o) ack_seen = 1;
    end
    repeat (2) begin
      @(posedge clock); #1;
      if (wb_ack_o) ack_seen = 1;
    end
    chk("drop_busy_fell", busy, 0);
    chk("drop_no_ack", ack_seen, 0);
    chk("drop_full_64_bits", last_n, 64);
    chk("drop_mosi_stream", cmd_sr, 32'h0300_0004);
    chk("drop_data_held", wb_dat_o, 32'h0000_0513);
    do_req(1'b0, 32'h8, 32'h0, 1'b0, lat);
    chk("after_drop_latency", lat, 1 + 128 * CLK_DIV);
    chk("after_drop_data", wb_dat_o, 32'haeaf_acad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
